// File: rtl/clk_prog_seq_pkg.sv
// Shared types and constants for the dcm frequency-code programming sequencer.
package clk_prog_seq_pkg;

  localparam int PROG_W_DEF = 3;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/clk_prog_rr_arb.sv
// Two-way round-robin arbiter; the tie pointer only moves when both sides request together.
module clk_prog_rr_arb
  import clk_prog_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr == REQ_B) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= REQ_A;
    end else if (advance && (req == 2'b11)) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/clk_prog_sequencer.sv
// Arbitrates two requesters and drives the dcm prog_in/update handshake, then waits for confirmation.
// Define CLK_PROG_SEQ_STEP_EN to walk the code toward the target one step per update pulse.
module clk_prog_sequencer
  import clk_prog_seq_pkg::*;
#(
  parameter int PROG_W      = PROG_W_DEF,
  parameter int UPD_PULSE_W = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [PROG_W-1:0] prog_a,
  input  logic              req_b,
  input  logic [PROG_W-1:0] prog_b,
  output logic              done_a,
  output logic              done_b,
  output logic              err_timeout,
  output logic              busy,
  output logic [PROG_W-1:0] dcm_prog_in,
  output logic              dcm_update,
  input  logic [PROG_W-1:0] dcm_prog_out,
  output logic [PROG_W-1:0] cur_prog,
  output state_t            dbg_state
);

  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int PCNT_W = $clog2(UPD_PULSE_W + 1);

  state_t            state, state_next;
  logic              owner;
  logic              err_flag;
  logic [1:0]        req_vec, armed, req_eff, gnt;
  logic [PROG_W-1:0] target, gnt_prog, sel_tgt, step_val;
  logic [CNT_W-1:0]  cnt;
  logic [PCNT_W-1:0] pcnt;
  logic              advance, confirmed, timeout_hit;

  // A requester is re-armed only after it lowers req, so a held level never re-triggers.
  assign req_vec = {req_b, req_a};
  assign req_eff = req_vec & armed;
  assign advance = (state == IDLE) && (|gnt);

  clk_prog_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst),
    .req     (req_eff),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    gnt_prog    = gnt[REQ_B] ? prog_b : prog_a;
    sel_tgt     = (state == IDLE) ? gnt_prog : target;
    step_val    = sel_tgt;
`ifdef CLK_PROG_SEQ_STEP_EN
    if (sel_tgt > cur_prog) begin
      step_val = cur_prog + PROG_W'(1);
    end else if (sel_tgt < cur_prog) begin
      step_val = cur_prog - PROG_W'(1);
    end
`endif
    confirmed   = (cur_prog == dcm_prog_in);
    timeout_hit = (state == WAIT) && !confirmed && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    state_next = state;
    case (state)
      IDLE:  if (advance) state_next = (gnt_prog == cur_prog) ? DONE : SETUP;
      SETUP: state_next = PULSE;
      PULSE: if (pcnt == PCNT_W'(UPD_PULSE_W - 1)) state_next = WAIT;
      WAIT: begin
        if (confirmed) begin
`ifdef CLK_PROG_SEQ_STEP_EN
          state_next = (dcm_prog_in == target) ? DONE : SETUP;
`else
          state_next = DONE;
`endif
        end else if (timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner       <= REQ_A;
      target      <= '0;
      err_flag    <= 1'b0;
      armed       <= 2'b11;
      cnt         <= '0;
      pcnt        <= '0;
      dcm_prog_in <= '0;
      dcm_update  <= 1'b0;
      cur_prog    <= '0;
    end else begin
      state      <= state_next;
      cur_prog   <= dcm_prog_out;
      dcm_update <= (state_next == PULSE);
      // prog_in only moves on SETUP entry, so it is stable across the whole update pulse.
      if (state_next == SETUP) dcm_prog_in <= step_val;

      if (state != WAIT) cnt <= '0;
      else if (cnt < CNT_W'(TIMEOUT_CYC)) cnt <= cnt + CNT_W'(1);

      if (state != PULSE) pcnt <= '0;
      else pcnt <= pcnt + PCNT_W'(1);

      if (advance) begin
        owner    <= gnt[REQ_B];
        target   <= gnt_prog;
        err_flag <= 1'b0;
      end else if (timeout_hit) begin
        err_flag <= 1'b1;
      end

      for (int i = 0; i < 2; i++) begin
        if (advance && gnt[i]) armed[i] <= 1'b0;
        else if (!req_vec[i]) armed[i] <= 1'b1;
      end
    end
  end

  // An owner that dropped req mid-transaction is already re-armed, which suppresses its done.
  assign busy        = (state != IDLE);
  assign done_a      = (state == DONE) && (owner == REQ_A) && !armed[REQ_A];
  assign done_b      = (state == DONE) && (owner == REQ_B) && !armed[REQ_B];
  assign err_timeout = err_flag && (done_a || done_b);
  assign dbg_state   = state;

endmodule

// File: tb/tb_clk_prog_sequencer.sv
// Directed bench for clk_prog_sequencer with a dcm model and a done-response scoreboard.
module tb_clk_prog_sequencer;
  import clk_prog_seq_pkg::*;

  localparam int PW       = 3;
  localparam int UPD      = 4;
  localparam int TO       = 1024;
  localparam int CONF_DLY = 3;
  localparam int W        = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic [PW-1:0] prog_a = '0, prog_b = '0, dcm_prog_out = '0;
  logic          done_a, done_b, err_timeout, busy, dcm_update;
  logic [PW-1:0] dcm_prog_in, cur_prog;
  state_t        dbg_state;

  int errors = 0;
  int checks = 0;
  logic [W-1:0]  exp_q[$];
  logic [PW-1:0] rise_codes[$];
  int            upd_rises = 0;
  int            upd_hi = 0;
  logic          upd_prev = 1'b0;
  logic [PW-1:0] upd_code = '0;
  bit            confirm_en = 1'b1;
  int            pend = 0;
  logic [PW-1:0] pend_code = '0;
  logic          m_prev = 1'b0;

  clk_prog_sequencer #(
    .PROG_W      (PW),
    .UPD_PULSE_W (UPD),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_a        (req_a),
    .prog_a       (prog_a),
    .req_b        (req_b),
    .prog_b       (prog_b),
    .done_a       (done_a),
    .done_b       (done_b),
    .err_timeout  (err_timeout),
    .busy         (busy),
    .dcm_prog_in  (dcm_prog_in),
    .dcm_update   (dcm_update),
    .dcm_prog_out (dcm_prog_out),
    .cur_prog     (cur_prog),
    .dbg_state    (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] resp(input logic who, input logic err, input logic [PW-1:0] cur);
    return {who, ~who, err, cur};
  endfunction

  // dcm model: latches prog_in on update rise, reflects it on prog_out CONF_DLY cycles later
  always @(negedge clk) begin
    if (!confirm_en) begin
      pend = 0;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) dcm_prog_out = pend_code;
    end
    if (confirm_en && dcm_update && !m_prev) begin
      pend      = CONF_DLY;
      pend_code = dcm_prog_in;
    end
    m_prev = dcm_update;
  end

  // monitor: update-pulse bookkeeping and done-response scoreboard
  always @(negedge clk) begin
    logic [W-1:0] got;
    if (dcm_update && !upd_prev) begin
      upd_rises++;
      upd_code = dcm_prog_in;
      rise_codes.push_back(dcm_prog_in);
    end
    if (dcm_update) begin
      upd_hi++;
      check("prog_in_stable", dcm_prog_in, upd_code);
    end
    upd_prev = dcm_update;
    got = {done_b, done_a, err_timeout, cur_prog};
    if (done_a || done_b || err_timeout) begin
      if (exp_q.size() == 0) check("unexpected_done", got, 0);
      else check("done_resp", got, exp_q.pop_front());
    end
  end

  task automatic serve(input logic who, input logic [PW-1:0] code, input int max_cyc,
                       input bit scramble, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    if (who == REQ_B) begin
      req_b = 1'b1; prog_b = code;
    end else begin
      req_a = 1'b1; prog_a = code;
    end
    for (int i = 1; i <= max_cyc && !seen; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("busy_after_req", busy, 1);
        if (scramble) begin
          if (who == REQ_B) prog_b = PW'($urandom_range(0, 7));
          else prog_a = PW'($urandom_range(0, 7));
        end
      end
      if ((who == REQ_B) ? done_b : done_a) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    if (who == REQ_B) req_b = 1'b0;
    else req_a = 1'b0;
    check("done_seen", seen, 1);
    @(negedge clk);
  endtask

  initial begin
    int lat, lat_b, r0, h0;
    bit seen;

    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done_a, done_b, err_timeout, dcm_update, dcm_prog_in, cur_prog}, 0);
    check("reset_state", dbg_state, IDLE);
    rst = 1'b1;
    @(negedge clk);

`ifdef CLK_PROG_SEQ_STEP_EN
    exp_q.push_back(resp(REQ_A, 1'b0, 3'd1));
    serve(REQ_A, 3'd1, 80, 1'b0, lat);
    rise_codes.delete();
    exp_q.push_back(resp(REQ_A, 1'b0, 3'd4));
    serve(REQ_A, 3'd4, 200, 1'b0, lat);
    check("step_rises", rise_codes.size(), 3);
    if (rise_codes.size() == 3) begin
      for (int i = 0; i < 3; i++) check("step_code", rise_codes[i], i + 2);
    end
`else
    // single request, code scrambled after grant must be ignored
    r0 = upd_rises; h0 = upd_hi;
    exp_q.push_back(resp(REQ_A, 1'b0, 3'd5));
    serve(REQ_A, 3'd5, 60, 1'b1, lat);
    check("t1_rises", upd_rises - r0, 1);
    check("t1_update_cycles", upd_hi - h0, UPD);
    check("t1_busy_low", busy, 0);

    // simultaneous requests: A first after reset, B first on the next tie
    exp_q.push_back(resp(REQ_A, 1'b0, 3'd2));
    exp_q.push_back(resp(REQ_B, 1'b0, 3'd6));
    fork
      serve(REQ_A, 3'd2, 60, 1'b0, lat);
      serve(REQ_B, 3'd6, 60, 1'b0, lat_b);
    join
    exp_q.push_back(resp(REQ_B, 1'b0, 3'd4));
    exp_q.push_back(resp(REQ_A, 1'b0, 3'd1));
    fork
      serve(REQ_A, 3'd1, 60, 1'b0, lat);
      serve(REQ_B, 3'd4, 60, 1'b0, lat_b);
    join

    // target equal to current code: no update pulse
    exp_q.push_back(resp(REQ_A, 1'b0, 3'd3));
    serve(REQ_A, 3'd3, 60, 1'b0, lat);
    r0 = upd_rises;
    exp_q.push_back(resp(REQ_B, 1'b0, 3'd3));
    serve(REQ_B, 3'd3, 2, 1'b0, lat);
    check("skip_no_update", upd_rises - r0, 0);
    check("skip_latency_ok", (lat >= 1) && (lat <= 2), 1);

    // dcm never confirms
    confirm_en = 1'b0;
    exp_q.push_back(resp(REQ_A, 1'b1, 3'd3));
    serve(REQ_A, 3'd6, TO + 50, 1'b1, lat);
    check("timeout_latency", lat, 1 + UPD + TO + 1);
    check("timeout_idle_after", dbg_state, IDLE);
    confirm_en = 1'b1;

    // owner withdraws mid-transaction: dcm still programmed, no done
    req_a = 1'b1; prog_a = 3'd7;
    repeat (3) @(negedge clk);
    req_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    check("drop_return_idle", seen, 1);
    @(negedge clk);
    check("drop_cur_prog", cur_prog, 7);

    // reset asserted during the update pulse
    confirm_en = 1'b0;
    req_a = 1'b1; prog_a = 3'd2;
    repeat (3) @(negedge clk);
    check("pulse_before_rst", dcm_update, 1);
    rst = 1'b0;
    #1;
    check("rst_update_low", dcm_update, 0);
    check("rst_busy_low", busy, 0);
    check("rst_prog_in", dcm_prog_in, 0);
    @(negedge clk);
    check("rst_no_done", {done_a, done_b}, 0);
    rst = 1'b1;
    confirm_en = 1'b1;
    r0 = upd_rises;
    exp_q.push_back(resp(REQ_A, 1'b0, 3'd2));
    serve(REQ_A, 3'd2, 60, 1'b0, lat);
    check("rst_regrant_rises", upd_rises - r0, 1);
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
